// File: rtl/oam_dma_engine.sv
// OAM DMA engine: a write to FF46 copies 160 bytes from page {FF46,00} (echo RAM
// folded onto C000-DFFF) into OAM, one byte every CYCLES_PER_BYTE clocks.
module oam_dma_engine #(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int START_DELAY     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ADDR,
    input  logic        WR,
    input  logic        RD,
    input  logic [7:0]  MMIO_DATA_out,
    output logic [7:0]  MMIO_DATA_in,
    output logic        DMA_RD,
    output logic [15:0] DMA_ADDR,
    input  logic [7:0]  DMA_DATA_in,
    output logic        OAM_WR,
    output logic [7:0]  OAM_ADDR,
    output logic [7:0]  OAM_DATA_out,
    output logic        DMA_ACTIVE
);

    localparam int SW = $clog2(CYCLES_PER_BYTE);
    localparam int DW = (START_DELAY > 2) ? $clog2(START_DELAY) : 1;
    localparam logic [SW-1:0] SLOT_RD    = '0;
    localparam logic [SW-1:0] SLOT_CAP   = SW'(1);
    localparam logic [SW-1:0] SLOT_WR    = SW'(2);
    localparam logic [SW-1:0] SLOT_LAST  = SW'(CYCLES_PER_BYTE - 1);
    localparam logic [DW-1:0] DELAY_INIT = DW'((START_DELAY > 0) ? START_DELAY - 1 : 0);
    localparam logic [7:0]    LAST_IDX   = 8'd159;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_XFER  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] delay_q, delay_d;
    logic [SW-1:0] slot_q, slot_d;
    logic [7:0]    byte_idx_q, byte_idx_d;
    logic [7:0]    src_hi_q, src_hi_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    ff46_q;

    logic          dma_rd_q, dma_rd_d;
    logic [15:0]   dma_addr_q, dma_addr_d;
    logic          oam_wr_q, oam_wr_d;
    logic [7:0]    oam_addr_q, oam_addr_d;
    logic [7:0]    oam_data_q, oam_data_d;
    logic          active_q, active_d;

    logic          ff46_wr;
    logic [7:0]    src_fold;
    logic          unused_rd;

    assign unused_rd = RD;
    assign ff46_wr   = WR && (ADDR == 16'hFF46);
    assign src_fold  = (MMIO_DATA_out < 8'hE0) ? MMIO_DATA_out : MMIO_DATA_out - 8'h20;

    assign MMIO_DATA_in = (ADDR == 16'hFF46) ? ff46_q : 8'hFF;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            delay_q    <= '0;
            slot_q     <= '0;
            byte_idx_q <= '0;
            src_hi_q   <= '0;
            data_q     <= '0;
            ff46_q     <= '0;
        end else begin
            state_q    <= state_d;
            delay_q    <= delay_d;
            slot_q     <= slot_d;
            byte_idx_q <= byte_idx_d;
            src_hi_q   <= src_hi_d;
            data_q     <= data_d;
            if (ff46_wr) begin
                ff46_q <= MMIO_DATA_out;
            end
        end
    end

    // An FF46 write overrides whatever the sequencer would do, including the final slot.
    always_comb begin
        state_d    = state_q;
        delay_d    = delay_q;
        slot_d     = slot_q;
        byte_idx_d = byte_idx_q;
        src_hi_d   = src_hi_q;
        case (state_q)
            S_START: begin
                if (delay_q == '0) begin
                    state_d = S_XFER;
                    slot_d  = '0;
                end else begin
                    delay_d = delay_q - DW'(1);
                end
            end
            S_XFER: begin
                if (slot_q == SLOT_LAST) begin
                    slot_d = '0;
                    if (byte_idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 8'd1;
                    end
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            default: begin
            end
        endcase
        if (ff46_wr) begin
            byte_idx_d = '0;
            src_hi_d   = src_fold;
            slot_d     = '0;
            delay_d    = DELAY_INIT;
            state_d    = (START_DELAY == 0) ? S_XFER : S_START;
        end
    end

    // Outputs are registered from the next state so each strobe lands in the cycle
    // its slot occupies rather than one cycle behind it.
    always_comb begin
        data_d     = ((state_q == S_XFER) && (slot_q == SLOT_CAP)) ? DMA_DATA_in : data_q;
        dma_rd_d   = (state_d == S_XFER) && (slot_d == SLOT_RD);
        dma_addr_d = dma_rd_d ? {src_hi_d, byte_idx_d} : dma_addr_q;
        oam_wr_d   = (state_d == S_XFER) && (slot_d == SLOT_WR);
        oam_addr_d = oam_wr_d ? byte_idx_d : oam_addr_q;
        oam_data_d = oam_wr_d ? data_d : oam_data_q;
        active_d   = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dma_rd_q   <= 1'b0;
            dma_addr_q <= '0;
            oam_wr_q   <= 1'b0;
            oam_addr_q <= '0;
            oam_data_q <= '0;
            active_q   <= 1'b0;
        end else begin
            dma_rd_q   <= dma_rd_d;
            dma_addr_q <= dma_addr_d;
            oam_wr_q   <= oam_wr_d;
            oam_addr_q <= oam_addr_d;
            oam_data_q <= oam_data_d;
            active_q   <= active_d;
        end
    end

    assign DMA_RD       = dma_rd_q;
    assign DMA_ADDR     = dma_addr_q;
    assign OAM_WR       = oam_wr_q;
    assign OAM_ADDR     = oam_addr_q;
    assign OAM_DATA_out = oam_data_q;
    assign DMA_ACTIVE   = active_q;

endmodule

// File: doc/oam_dma_engine.md
# oam_dma_engine

- Performs OAM DMA, the write side of the sprite attribute table that the PPU scans in OAM-scan mode.
- A CPU write to FF46 starts a 160-byte copy from source page `{FF46, 8'h00}` into OAM (FE00–FE9F).
- It sits beside the PPU on the MMIO bus, reads the source through the system memory port, and writes OAM through a dedicated byte port.
- `DMA_ACTIVE` tells the bus fabric to block CPU and PPU OAM access while a transfer runs.

## Interface

Parameters:
- `CYCLES_PER_BYTE`, default 4: clock cycles per transferred byte; must be ≥ 3.
- `START_DELAY`, default 4: idle cycles between the FF46 write and the first source read.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `clk`, input, 1: system clock.
- `rst`, input, 1: asynchronous active-high reset.
- `ADDR`, input, 16: CPU bus address.
- `WR`, input, 1: CPU write strobe, sampled at the `clk` edge.
- `RD`, input, 1: CPU read strobe; unused internally, present for bus uniformity.
- `MMIO_DATA_out`, input, 8: CPU write data.
- `MMIO_DATA_in`, output, 8: readback; equals FF46 when `ADDR == 16'hFF46`, else `8'hFF`.
- `DMA_RD`, output, 1: source read request.
- `DMA_ADDR`, output, 16: source byte address.
- `DMA_DATA_in`, input, 8: source data, valid the cycle after `DMA_RD`.
- `OAM_WR`, output, 1: OAM write strobe, one cycle per byte.
- `OAM_ADDR`, output, 8: OAM index, 0–159.
- `OAM_DATA_out`, output, 8: OAM write data.
- `DMA_ACTIVE`, output, 1: transfer in progress.

## Operation

- Register FF46:
  - Written when `WR && ADDR == 16'hFF46`.
  - Holds the raw written value; reset value 0.
- Source base page:
  - `src_hi = FF46` when FF46 < 8'hE0.
  - Otherwise `src_hi = FF46 - 8'h20` (echo-RAM fold onto C000–DFFF).
- State machine:
  - IDLE: no activity. An FF46 write moves to START, loads `delay_cnt = START_DELAY-1`, clears `byte_idx` to 0, latches `src_hi`.
  - START: decrement `delay_cnt`; when 0, go to XFER with `slot_cnt = 0`. With `START_DELAY = 0`, skip START entirely.
  - XFER, per slot:
    - `slot_cnt == 0`: `DMA_RD = 1`, `DMA_ADDR = {src_hi, byte_idx}`.
    - `slot_cnt == 1`: capture `DMA_DATA_in` into `data_q`.
    - `slot_cnt == 2`: `OAM_WR = 1`, `OAM_ADDR = byte_idx`, `OAM_DATA_out = data_q`.
    - `slot_cnt == CYCLES_PER_BYTE-1`: `slot_cnt <= 0`. If `byte_idx == 159`, go to IDLE; else `byte_idx <= byte_idx + 1`.
- Widths and limits:
  - `byte_idx` is 8 bits and never exceeds 159; no wrap to 160 is ever issued.
  - `slot_cnt` is sized `$clog2(CYCLES_PER_BYTE)`.
- `DMA_ACTIVE = (state != IDLE)`.
- Restart: an FF46 write in START or XFER aborts the current transfer.
  - Go to START with the new source and `byte_idx = 0`.
  - An `OAM_WR` scheduled in that same cycle is suppressed.
  - Bytes already written stay in OAM.
- Writes to any other address have no effect.

## Timing

- Reset values (async `rst`): state IDLE; FF46 = 0; `DMA_RD = 0`; `DMA_ADDR = 0`; `OAM_WR = 0`; `OAM_ADDR = 0`; `OAM_DATA_out = 0`; `DMA_ACTIVE = 0`.
- Reset mid-transfer: abort immediately; OAM keeps its partial contents.
- All outputs are registered except `MMIO_DATA_in`, which is combinational.
- Counting from the FF46 write edge as cycle 0:
  - `DMA_ACTIVE` rises at cycle 1.
  - First `DMA_RD` at cycle `1 + START_DELAY`.
  - Byte *n*: `DMA_RD` at cycle `1 + START_DELAY + n·CYCLES_PER_BYTE`; `OAM_WR` two cycles later.
  - `DMA_ACTIVE` falls at cycle `1 + START_DELAY + 160·CYCLES_PER_BYTE`.
  - With defaults that is cycle 645, i.e. a 644-cycle active window.
- `DMA_RD` and `OAM_WR` are single-cycle pulses and are never asserted together.
- Simultaneous FF46 write and final slot cycle: the restart wins; no return to IDLE.
- Readback of FF46 reflects the new value from the cycle after the write.

## Test plan

- **Basic copy:** FF46 ← 8'hC1, source C100+i = i ^ 8'h5A.
  - OAM[i] = i ^ 8'h5A for i = 0–159.
  - Exactly 160 `OAM_WR` pulses.
  - `DMA_ACTIVE` high for 644 cycles.
- **Cycle timing:** FF46 ← 8'h80 at cycle 0.
  - First `DMA_RD` at cycle 5 with `DMA_ADDR = 16'h8000`.
  - First `OAM_WR` at cycle 7 with `OAM_ADDR = 0`.
  - Last `OAM_WR` at cycle 643 with `OAM_ADDR = 159`.
- **Echo fold:** FF46 ← 8'hF3.
  - `DMA_ADDR` runs D300–D39F.
  - Reading FF46 returns 8'hF3.
- **Restart:** FF46 ← 8'hC0, then FF46 ← 8'hC2 at cycle 100.
  - `byte_idx` restarts at 0, with first new `DMA_ADDR = 16'hC200` at cycle 105.
  - `DMA_ACTIVE` stays high continuously until cycle 745.
- **Reset mid-transfer:** assert `rst` asynchronously at cycle 300.
  - All outputs go to 0 immediately; FF46 reads 0.
  - No further `OAM_WR`.
- **Readback isolation:** read FF47 → 8'hFF; write FF45 → no `DMA_ACTIVE`.
